// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared LEGv8 control encodings, opcode constants and state/class enums
package legv8_pkg;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
    localparam logic [5:0]  OP_B_PFX   = 6'b000101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_BTGT   = 2'b10;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        WB_R     = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        WB_LD    = 4'd6,
        MEM_WR   = 4'd7,
        BR_CBZ   = 4'd8,
        BR_B     = 4'd9,
        TRAP     = 4'd10
    } legv8_state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_LDUR    = 3'd1,
        CLS_STUR    = 3'd2,
        CLS_CBZ     = 3'd3,
        CLS_B       = 3'd4,
        CLS_ILLEGAL = 3'd5
    } legv8_class_t;

endpackage

// File: rtl/legv8_op_class.sv
// rtl/legv8_op_class.sv - combinational LEGv8 opcode to instruction-class decoder
module legv8_op_class
    import legv8_pkg::*;
(
    input  logic [10:0]  op_code,
    output legv8_class_t op_class
);

    // Exact R/D-format matches first, then the prefix-coded branch formats.
    always_comb begin
        op_class = CLS_ILLEGAL;
        if (op_code == OP_ADD || op_code == OP_SUB || op_code == OP_AND || op_code == OP_ORR)
            op_class = CLS_RTYPE;
        else if (op_code == OP_LDUR)
            op_class = CLS_LDUR;
        else if (op_code == OP_STUR)
            op_class = CLS_STUR;
        else if (op_code[10:3] == OP_CBZ_PFX)
            op_class = CLS_CBZ;
        else if (op_code[10:5] == OP_B_PFX)
            op_class = CLS_B;
    end

endmodule

// File: rtl/legv8_mc_control.sv
// rtl/legv8_mc_control.sv - LEGv8 multicycle main control FSM (optional perf counters: LEGV8_PERF_CNT_EN)
module legv8_mc_control
    import legv8_pkg::*;
#(
    parameter int unsigned FETCH_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] op_code,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [1:0]  ALUOp,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic [1:0]  PCSource,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IorD,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        Reg2Loc,
    output logic        illegal,
    output logic [3:0]  state
`ifdef LEGV8_PERF_CNT_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
`endif
);

    legv8_state_t state_q;
    legv8_class_t op_class;
    logic         is_load_q;
    logic         illegal_q;
    logic [31:0]  wait_cnt;
    logic         mem_state;
    logic         mem_wait;
    logic         timeout_hit;
    logic         unused_zero;

    // The zero flag qualifies the PC load in the datapath, not the sequencing.
    assign unused_zero = zero;

    legv8_op_class u_op_class (
        .op_code  (op_code),
        .op_class (op_class)
    );

    assign mem_state   = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    assign mem_wait    = mem_state && !mem_ready;
    assign timeout_hit = (FETCH_TIMEOUT != 0) && mem_wait && (wait_cnt + 32'd1 == FETCH_TIMEOUT);

    assign state   = state_q;
    assign illegal = illegal_q;

    // Sequencer: state, remembered load/store direction, memory wait counter, sticky trap flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            is_load_q <= 1'b0;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
        end else begin
            wait_cnt <= mem_wait ? wait_cnt + 32'd1 : 32'd0;
            if (timeout_hit) begin
                state_q   <= TRAP;
                illegal_q <= 1'b1;
            end else begin
                case (state_q)
                    FETCH:    if (mem_ready) state_q <= DECODE;
                    DECODE: begin
                        is_load_q <= (op_class == CLS_LDUR);
                        case (op_class)
                            CLS_RTYPE:          state_q <= EXEC_R;
                            CLS_LDUR, CLS_STUR: state_q <= MEM_ADDR;
                            CLS_CBZ:            state_q <= BR_CBZ;
                            CLS_B:              state_q <= BR_B;
                            default: begin
                                state_q   <= TRAP;
                                illegal_q <= 1'b1;
                            end
                        endcase
                    end
                    EXEC_R:   state_q <= WB_R;
                    WB_R:     state_q <= FETCH;
                    MEM_ADDR: state_q <= is_load_q ? MEM_RD : MEM_WR;
                    MEM_RD:   if (mem_ready) state_q <= WB_LD;
                    WB_LD:    state_q <= FETCH;
                    MEM_WR:   if (mem_ready) state_q <= FETCH;
                    BR_CBZ:   state_q <= FETCH;
                    BR_B:     state_q <= FETCH;
                    default: begin
                        state_q   <= TRAP;
                        illegal_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Moore control decode; reset forces the idle pattern at once so no write survives rst.
    always_comb begin
        ALUOp       = ALUOP_ADD;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = PCSRC_ALU;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        Reg2Loc     = 1'b0;
        if (rst) begin
            ALUSrcB = SRCB_FOUR;
        end else begin
            case (state_q)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                DECODE: begin
                    ALUSrcB = SRCB_BROFF;
                    Reg2Loc = (op_class == CLS_STUR) || (op_class == CLS_CBZ);
                end
                EXEC_R: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_RTYPE;
                end
                WB_R:     RegWrite = 1'b1;
                MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                MEM_RD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                WB_LD: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                MEM_WR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    Reg2Loc  = 1'b1;
                end
                BR_CBZ: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALUOP_PASSB;
                    Reg2Loc     = 1'b1;
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                end
                BR_B: begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_BTGT;
                end
                default: ;
            endcase
        end
    end

`ifdef LEGV8_PERF_CNT_EN
    logic retire;

    // Every path back to FETCH leaves from one of these states.
    assign retire = (state_q == WB_R) || (state_q == WB_LD) || (state_q == BR_CBZ) ||
                    (state_q == BR_B) || ((state_q == MEM_WR) && mem_ready);

    // Free-running activity counters; both wrap naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (state_q != TRAP)
                cycle_count <= cycle_count + 32'd1;
            if (retire && !timeout_hit)
                instr_count <= instr_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_legv8_mc_control.sv
// tb/tb_legv8_mc_control.sv - self-checking bench for the LEGv8 multicycle control FSM
module tb_legv8_mc_control;
    import legv8_pkg::*;

    localparam int TO = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic [10:0] op_code = '0;
    logic [1:0]  ALUOp, ALUSrcB, PCSource;
    logic        ALUSrcA, IRWrite, PCWrite, PCWriteCond, MemRead, MemWrite;
    logic        IorD, MemtoReg, RegWrite, Reg2Loc, illegal;
    logic [3:0]  state;
`ifdef LEGV8_PERF_CNT_EN
    logic [31:0] cycle_count, instr_count;
`endif

    always #5 clk = ~clk;

    legv8_mc_control #(.FETCH_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .op_code     (op_code),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .ALUOp       (ALUOp),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .IRWrite     (IRWrite),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .PCSource    (PCSource),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IorD        (IorD),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .Reg2Loc     (Reg2Loc),
        .illegal     (illegal),
        .state       (state)
`ifdef LEGV8_PERF_CNT_EN
        ,
        .cycle_count (cycle_count),
        .instr_count (instr_count)
`endif
    );

    typedef struct packed {
        legv8_state_t st;
        logic         mr;
    } step_t;

    typedef struct {
        logic [10:0]  op;
        int           sf;
        int           sm;
        int           exp_len;
        legv8_state_t exp_end;
        int           exp_rw;
        int           exp_mrd;
    } vec_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    step_t tr[$];
    logic  end_trap;

    localparam logic [20:0] RST_ROW = {4'd0, 2'b00, 1'b0, 2'b01, 12'b0};

    function automatic logic [20:0] pk(input logic [3:0] st, input logic [1:0] aluop, input logic srca,
                                       input logic [1:0] srcb, input logic irw, input logic pcw,
                                       input logic pcwc, input logic [1:0] pcsrc, input logic mrd,
                                       input logic mwr, input logic iord, input logic m2r,
                                       input logic rw, input logic r2, input logic ill);
        return {st, aluop, srca, srcb, irw, pcw, pcwc, pcsrc, mrd, mwr, iord, m2r, rw, r2, ill};
    endfunction

    function automatic logic [20:0] act_vec();
        return pk(state, ALUOp, ALUSrcA, ALUSrcB, IRWrite, PCWrite, PCWriteCond, PCSource,
                  MemRead, MemWrite, IorD, MemtoReg, RegWrite, Reg2Loc, illegal);
    endfunction

    // Expected control pattern for each phase of an instruction.
    function automatic logic [20:0] exp_row(input legv8_state_t s, input logic mr, input logic r2l);
        case (s)
            FETCH:    return pk(s, 2'b00, 1'b0, 2'b01, mr, mr, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            DECODE:   return pk(s, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, r2l, 1'b0);
            EXEC_R:   return pk(s, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            WB_R:     return pk(s, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            MEM_ADDR: return pk(s, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            MEM_RD:   return pk(s, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            WB_LD:    return pk(s, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            MEM_WR:   return pk(s, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            BR_CBZ:   return pk(s, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            BR_B:     return pk(s, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            default:  return pk(s, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        endcase
    endfunction

    // 0 R-type, 1 LDUR, 2 STUR, 3 CBZ, 4 B, 5 illegal
    function automatic int cls_of(input logic [10:0] op);
        if (op inside {11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000}) return 0;
        if (op == 11'b11111000010) return 1;
        if (op == 11'b11111000000) return 2;
        if (op ==? 11'b10110100???) return 3;
        if (op ==? 11'b000101?????) return 4;
        return 5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic put(input legv8_state_t s);
        tr.push_back('{st: s, mr: 1'b1});
    endtask

    // A memory phase that waits n cycles; returns 1 when the wait runs into the timeout.
    function automatic bit push_mem(input legv8_state_t s, input int n);
        for (int i = 0; i < n && i < TO; i++) tr.push_back('{st: s, mr: 1'b0});
        if (n >= TO) begin
            end_trap = 1'b1;
            return 1'b1;
        end
        tr.push_back('{st: s, mr: 1'b1});
        return 1'b0;
    endfunction

    // Expected phase sequence of one instruction with sf fetch and sm memory wait cycles.
    task automatic build_trace(input logic [10:0] op, input int sf, input int sm);
        tr.delete();
        end_trap = 1'b0;
        if (push_mem(FETCH, sf)) return;
        put(DECODE);
        case (cls_of(op))
            0: begin put(EXEC_R); put(WB_R); end
            1: begin put(MEM_ADDR); if (!push_mem(MEM_RD, sm)) put(WB_LD); end
            2: begin put(MEM_ADDR); void'(push_mem(MEM_WR, sm)); end
            3: put(BR_CBZ);
            4: put(BR_B);
            default: end_trap = 1'b1;
        endcase
    endtask

    // Drives the trace one cycle at a time; op_code is garbage outside DECODE.
    task automatic run_trace(input logic [10:0] op, input int limit, output int rw_n, output int mrd_n, output int cyc_n);
        logic r2l;
        r2l = (cls_of(op) == 2) || (cls_of(op) == 3);
        rw_n = 0;
        mrd_n = 0;
        cyc_n = 0;
        for (int i = 0; i < tr.size() && i < limit; i++) begin
            op_code = (tr[i].st == DECODE) ? op : 11'($urandom);
            mem_ready = (tr[i].st inside {FETCH, MEM_RD, MEM_WR}) ? tr[i].mr : 1'($urandom);
            zero = 1'($urandom);
            #1;
            check($sformatf("cycle_%s", tr[i].st.name()), {11'b0, act_vec()}, {11'b0, exp_row(tr[i].st, tr[i].mr, r2l)});
            rw_n += int'(RegWrite);
            mrd_n += int'(MemRead & IorD);
            cyc_n++;
            if (i != limit - 1) @(negedge clk);
        end
    endtask

    task automatic trap_hold(input int n);
        for (int i = 0; i < n; i++) begin
            op_code = 11'($urandom);
            mem_ready = 1'($urandom);
            zero = 1'($urandom);
            #1;
            check("trap_hold", {11'b0, act_vec()}, {11'b0, exp_row(TRAP, 1'b0, 1'b0)});
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", {11'b0, act_vec()}, {11'b0, RST_ROW});
        @(negedge clk);
        check("rst_hold", {11'b0, act_vec()}, {11'b0, RST_ROW});
        rst = 1'b0;
    endtask

    initial begin
        vec_t        vt[9];
        int          rw_n, mrd_n, cyc_n;
        logic [10:0] op;
        int          sel, sf, sm;

        vt[0] = '{11'b10001011000, 0, 0, 4, FETCH, 1, 0};
        vt[1] = '{11'b11111000010, 0, 3, 8, FETCH, 1, 4};
        vt[2] = '{11'b11111000000, 0, 0, 4, FETCH, 0, 0};
        vt[3] = '{11'b10110100101, 0, 0, 3, FETCH, 0, 0};
        vt[4] = '{11'b00010111111, 0, 0, 3, FETCH, 0, 0};
        vt[5] = '{11'b11001011000, 2, 0, 6, FETCH, 1, 0};
        vt[6] = '{11'b00000000000, 0, 0, 2, TRAP,  0, 0};
        vt[7] = '{11'b10101010000, 5, 0, 5, TRAP,  0, 0};
        vt[8] = '{11'b11111000000, 0, 5, 8, TRAP,  0, 0};

        for (int k = 0; k < 9; k++) begin
            do_reset();
            build_trace(vt[k].op, vt[k].sf, vt[k].sm);
            run_trace(vt[k].op, 1000, rw_n, mrd_n, cyc_n);
            check($sformatf("end_state_len_%0d", k), {20'b0, state, 8'(cyc_n)}, {20'b0, vt[k].exp_end, 8'(vt[k].exp_len)});
            check($sformatf("regwrite_cycles_%0d", k), rw_n, vt[k].exp_rw);
            check($sformatf("mem_rd_cycles_%0d", k), mrd_n, vt[k].exp_mrd);
            if (vt[k].exp_end == TRAP) trap_hold(4);
        end

        // Reset lands inside a stalled MEM_WR, between clock edges.
        do_reset();
        build_trace(11'b11111000000, 0, 3);
        run_trace(11'b11111000000, 4, rw_n, mrd_n, cyc_n);
        do_reset();

        for (int n = 0; n < 80; n++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0: op = 11'b10001011000;
                1: op = 11'b11001011000;
                2: op = 11'b10001010000;
                3: op = 11'b10101010000;
                4: op = 11'b11111000010;
                5: op = 11'b11111000000;
                6: op = {8'b10110100, 3'($urandom)};
                7: op = {6'b000101, 5'($urandom)};
                default: op = 11'($urandom);
            endcase
            sf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 0;
            sm = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : 0;
            build_trace(op, sf, sm);
            run_trace(op, 1000, rw_n, mrd_n, cyc_n);
            check("rnd_end_state", {28'b0, state}, {28'b0, (end_trap ? TRAP : FETCH)});
            if (end_trap) begin
                trap_hold(2);
                do_reset();
            end
        end

`ifdef LEGV8_PERF_CNT_EN
        do_reset();
        check("instr_count_rst", instr_count, 32'd0);
        for (int n = 0; n < 10; n++) begin
            build_trace(11'b00010100000, 0, 0);
            run_trace(11'b00010100000, 1000, rw_n, mrd_n, cyc_n);
        end
        check("instr_count", instr_count, 32'd10);
        check("cycle_count", cycle_count, 32'd30);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
